// File: rtl/shift_pkg.sv
// ==========================================================================
// shift_pkg: shared Mode and FSM state encodings for iter_shifter | rev 1.0
// ==========================================================================
`default_nettype none

package shift_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRA = 2'b01,
    MODE_ROR = 2'b10,
    MODE_SRL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ==========================================================================
// shift_step: combinational one-bit move of data per mode | rev 1.0
// ==========================================================================
`default_nettype none

module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  input  mode_e            mode,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = data;
    case (mode)
      MODE_SLL: result = {data[WIDTH-2:0], 1'b0};
      MODE_SRA: result = {data[WIDTH-1], data[WIDTH-1:1]};
      MODE_ROR: result = {data[0], data[WIDTH-1:1]};
      MODE_SRL: result = {1'b0, data[WIDTH-1:1]};
      default:  result = data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/iter_shifter.sv
// ==========================================================================
// iter_shifter: multi-cycle shifter, one bit position per clock | rev 1.0
// ==========================================================================
`default_nettype none

module iter_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] Shift_In,
  input  logic [CNT_W-1:0] Shift_Val,
  input  logic [1:0]       Mode,
  output logic [WIDTH-1:0] Shift_Out,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  state_e           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] stepped;
  mode_e            mode_q;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data   (work),
    .mode   (mode_q),
    .result (stepped)
  );

  // busy is kept as its own register so it tracks state without decode glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      work      <= '0;
      mode_q    <= MODE_SLL;
      Shift_Out <= '0;
      zero      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            work   <= Shift_In;
            count  <= Shift_Val;
            mode_q <= mode_e'(Mode);
            busy   <= 1'b1;
            state  <= (Shift_Val != '0) ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          work  <= stepped;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          Shift_Out <= work;
          zero      <= (work == '0);
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/iter_shifter.md
ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits.
REQ-002 SHALL have parameter CNT_W, default 4, shift-amount width; $clog2(WIDTH).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port Shift_In  input  WIDTH  operand; captured on an accepted start.
REQ-007 SHALL have port Shift_Val  input  CNT_W  shift amount, 0..WIDTH-1; captured on an accepted start.
REQ-008 SHALL have port Mode  input  2  operation: 00 SLL, 01 SRA, 10 ROR, 11 SRL; captured on an accepted start.
REQ-009 SHALL have port Shift_Out  output  WIDTH  registered result.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port done  output  1  single-cycle pulse; Shift_Out valid.
REQ-012 SHALL have port zero  output  1  high when the final Shift_Out is all zeros; updates with done.

Function
REQ-013 SHALL implement an FSM with states IDLE, SHIFT, DONE.
REQ-014 IDLE: start=1 SHALL accept: capture operand into work register, Shift_Val into count, Mode; next SHIFT if Shift_Val!=0, else DONE.
REQ-015 SHIFT: each cycle SHALL move the work register by exactly one bit per the captured Mode and decrement count; next DONE when count==1, else stay.
REQ-016 Per-step rules SHALL be: SLL fill 0 at LSB; SRA replicate MSB; SRL fill 0 at MSB; ROR old LSB goes to MSB.
REQ-017 DONE: SHALL load Shift_Out and zero from the work register, pulse done for exactly one cycle, then return to IDLE.
REQ-018 Latency SHALL be Shift_Val+1 cycles from the accepting edge to the done cycle; Shift_Val=0 SHALL give done on the next cycle with Shift_Out=Shift_In.
REQ-019 start while busy SHALL be ignored; no operand capture, no effect on the in-flight operation.
REQ-020 start asserted in the DONE cycle SHALL be ignored; a new request SHALL be accepted on the following IDLE cycle at the earliest.
REQ-021 Shift_Out and zero SHALL hold their values between done pulses and change only in the DONE state.
REQ-022 Inputs other than start SHALL be don't-care outside the accepting cycle.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, count=0, work register=0, Shift_Out=0, zero=0, busy=0, done=0.
REQ-024 Reset mid-operation SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Structure
REQ-025 A shared package shift_pkg SHALL hold the Mode enum (SLL, SRA, ROR, SRL with encodings per REQ-008) and the FSM state enum.
REQ-026 The one-bit step SHALL be a combinational sub-module shift_step (inputs: data, mode; output: data moved one bit); iter_shifter instantiates one.

Verification
REQ-027 SLL: Shift_In=0x0001, Shift_Val=15 -> done 16 cycles after accept, Shift_Out=0x8000, zero=0.
REQ-028 SRA: Shift_In=0x8000, Shift_Val=4 -> Shift_Out=0xF800; SRL with same operands -> 0x0800.
REQ-029 ROR: Shift_In=0x0001, Shift_Val=1 -> Shift_Out=0x8000; ROR 0x1234 by 8 -> 0x3412.
REQ-030 Shift_Val=0, any Mode, Shift_In=0xA5A5 -> done 1 cycle after accept, Shift_Out=0xA5A5; SLL 0x8000 by 1 -> 0x0000, zero=1.
REQ-031 start pulsed with new operands every cycle of a 10-cycle operation -> only the first accepted; single done with the first operation's result.
REQ-032 rst_n asserted in SHIFT with count=5 -> all outputs 0 immediately, no done; subsequent start SLL 0x0003 by 2 -> Shift_Out=0x000C.
